// File: rtl/pf_req_filter_queue.sv
// Prefetch request filter queue: buffers SPP prefetch requests ahead of the L2 arbiter,
// drops duplicates of queued or recently issued blocks and merges needT upgrades.
// Ports: clock/reset (sync, active-high), pf_l2_pf_en (0 flushes),
//        in_* request from the prefetcher (never back-pressured),
//        out_* request towards the arbiter, stat_* saturating statistics.
module pf_req_filter_queue #(
    parameter int TAG_W          = 21,
    parameter int SET_W          = 9,
    parameter int SRC_W          = 7,
    parameter int QUEUE_DEPTH    = 4,
    parameter int FILTER_ENTRIES = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pf_l2_pf_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_bits_tag,
    input  logic [SET_W-1:0] in_bits_set,
    input  logic             in_bits_needT,
    input  logic [SRC_W-1:0] in_bits_source,
    input  logic             in_bits_isBOP,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_bits_tag,
    output logic [SET_W-1:0] out_bits_set,
    output logic             out_bits_needT,
    output logic [SRC_W-1:0] out_bits_source,
    output logic             out_bits_isBOP,
    output logic [CNT_W-1:0] stat_issued,
    output logic [CNT_W-1:0] stat_drop_dup,
    output logic [CNT_W-1:0] stat_drop_full,
    output logic [CNT_W-1:0] stat_merge
);

    localparam int KEY_W = TAG_W + SET_W;
    localparam int QP_W  = $clog2(QUEUE_DEPTH);
    localparam int OC_W  = QP_W + 1;
    localparam int FP_W  = $clog2(FILTER_ENTRIES);

    logic [TAG_W-1:0] q_tag_q   [QUEUE_DEPTH];
    logic [SET_W-1:0] q_set_q   [QUEUE_DEPTH];
    logic [SRC_W-1:0] q_src_q   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_needT_q;
    logic [QUEUE_DEPTH-1:0] q_bop_q;

    logic [KEY_W-1:0]          f_key_q [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] f_vld_q;

    logic [QP_W-1:0] head_q, head_d;
    logic [QP_W-1:0] tail_q, tail_d;
    logic [OC_W-1:0] cnt_q, cnt_d;
    logic [FP_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [CNT_W-1:0] issued_q, drop_dup_q, drop_full_q, merge_q;

    logic [KEY_W-1:0]       in_key;
    logic [KEY_W-1:0]       head_key;
    logic [QUEUE_DEPTH-1:0] q_vld;
    logic [QUEUE_DEPTH-1:0] q_hit;
    logic [QUEUE_DEPTH-1:0] merge_vec;
    logic                   f_hit;
    logic [QP_W-1:0]        rel;
    logic                   nonempty, full;
    logic                   in_fire, out_fire;
    logic                   any_hit, do_merge;
    logic                   act_dis, act_merge, act_dup, act_full, enq;
    logic                   head_merge;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_key   = {in_bits_tag, in_bits_set};
    assign head_key = {q_tag_q[head_q], q_set_q[head_q]};
    assign nonempty = (cnt_q != '0);
    assign full     = (cnt_q == OC_W'(QUEUE_DEPTH));
    assign in_ready = ~reset;
    assign out_valid = nonempty & pf_l2_pf_en;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Match set: every occupied queue slot (head included even while it
    // fires) plus every valid filter entry.
    always_comb begin
        q_vld     = '0;
        q_hit     = '0;
        merge_vec = '0;
        f_hit     = 1'b0;
        rel       = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            rel          = QP_W'(i) - head_q;
            q_vld[i]     = ({1'b0, rel} < cnt_q);
            q_hit[i]     = q_vld[i] && ({q_tag_q[i], q_set_q[i]} == in_key);
            merge_vec[i] = q_hit[i] && !q_needT_q[i] && in_bits_needT;
        end
        for (int j = 0; j < FILTER_ENTRIES; j++) begin
            if (f_vld_q[j] && (f_key_q[j] == in_key)) begin
                f_hit = 1'b1;
            end
        end
    end

    // One action per accepted request, highest priority first.
    always_comb begin
        any_hit    = (|q_hit) | f_hit;
        do_merge   = |merge_vec;
        act_dis    = in_fire & ~pf_l2_pf_en;
        act_merge  = in_fire & pf_l2_pf_en & do_merge;
        act_dup    = in_fire & pf_l2_pf_en & ~do_merge & any_hit;
        act_full   = in_fire & pf_l2_pf_en & ~do_merge & ~any_hit
                     & full & ~out_fire;
        enq        = in_fire & pf_l2_pf_en & ~do_merge & ~any_hit
                     & ~(full & ~out_fire);
        head_merge = act_merge & merge_vec[head_q];
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (!pf_l2_pf_en) begin
            head_d   = '0;
            tail_d   = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + 1'b1;
            end
            if (out_fire) begin
                head_d   = head_q + 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            unique case ({enq, out_fire})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            f_vld_q     <= '0;
            q_needT_q   <= '0;
            q_bop_q     <= '0;
            issued_q    <= '0;
            drop_dup_q  <= '0;
            drop_full_q <= '0;
            merge_q     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_tag_q[i] <= '0;
                q_set_q[i] <= '0;
                q_src_q[i] <= '0;
            end
            for (int j = 0; j < FILTER_ENTRIES; j++) begin
                f_key_q[j] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            if (!pf_l2_pf_en) begin
                f_vld_q <= '0;
            end else if (out_fire) begin
                f_key_q[wr_ptr_q] <= head_key;
                f_vld_q[wr_ptr_q] <= 1'b1;
            end
            if (enq) begin
                q_tag_q[tail_q]   <= in_bits_tag;
                q_set_q[tail_q]   <= in_bits_set;
                q_src_q[tail_q]   <= in_bits_source;
                q_needT_q[tail_q] <= in_bits_needT;
                q_bop_q[tail_q]   <= in_bits_isBOP;
            end
            if (act_merge) begin
                q_needT_q <= q_needT_q | merge_vec;
            end
            if (out_fire) begin
                issued_q <= sat_inc(issued_q);
            end
            if (act_dup) begin
                drop_dup_q <= sat_inc(drop_dup_q);
            end
            if (act_dis | act_full) begin
                drop_full_q <= sat_inc(drop_full_q);
            end
            if (act_merge) begin
                merge_q <= sat_inc(merge_q);
            end
        end
    end

    // Head is presented whenever occupied; a same-cycle merge into the
    // head must already show up as needT.
    always_comb begin
        out_bits_tag    = '0;
        out_bits_set    = '0;
        out_bits_needT  = 1'b0;
        out_bits_source = '0;
        out_bits_isBOP  = 1'b0;
        if (nonempty) begin
            out_bits_tag    = q_tag_q[head_q];
            out_bits_set    = q_set_q[head_q];
            out_bits_needT  = q_needT_q[head_q] | head_merge;
            out_bits_source = q_src_q[head_q];
            out_bits_isBOP  = q_bop_q[head_q];
        end
    end

    assign stat_issued    = issued_q;
    assign stat_drop_dup  = drop_dup_q;
    assign stat_drop_full = drop_full_q;
    assign stat_merge     = merge_q;

endmodule
